sync_period_measure: RTL

- Measures one raw video sync line (hsync or vsync) and reports, per sync period, the period length in clocks, the active pulse width and the inferred active polarity.
- Sits directly upstream of the count validator: o_v/o_period (or o_v/o_width) drive its strobe/value inputs, one report per completed period.
- Also reports loss of sync, as a zero-valued report, when no edge arrives before the counter saturates.

---
 rtl/sync_period_measure_if.sv | 22 ++
 rtl/sync_period_measure.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sync_period_measure_if.sv
// Sync-line measurement bundle: raw sync in, per-period report out.
// master = sync source / report consumer, slave = the measurement block.
interface sync_period_measure_if #(
  parameter int NBITS = 16
);
  logic             i_sync;
  logic             o_v;
  logic [NBITS-1:0] o_period;
  logic [NBITS-1:0] o_width;
  logic             o_pol;
  logic             o_lost;

  modport master (
    output i_sync,
    input  o_v, o_period, o_width, o_pol, o_lost
  );

  modport slave (
    input  i_sync,
    output o_v, o_period, o_width, o_pol, o_lost
  );
endinterface

// File: rtl/sync_period_measure.sv
// Measures period, active pulse width and polarity of one raw sync line.
// Optional macro SYNC_PERIOD_MEASURE_CDC_EN adds a 2-FF input synchronizer.
module sync_period_measure #(
  parameter int NBITS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  sync_period_measure_if.slave bus
);
  typedef enum logic {S_WAIT = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [NBITS-1:0] CNT_MAX = '1;
  localparam logic [NBITS-1:0] CNT_ONE = NBITS'(1);

  state_t           state_q, state_d;
  logic [NBITS-1:0] cnt_q, cnt_d;
  logic [NBITS-1:0] hcnt_q, hcnt_d;
  logic             s_sync_q, s_last_q;
  logic             v_q, v_d;
  logic             lost_q, lost_d;
  logic [NBITS-1:0] period_q, period_d;
  logic [NBITS-1:0] width_q, width_d;
  logic             pol_q, pol_d;

  logic             sync_in;
  logic             rise;
  logic [NBITS-1:0] low_cnt;
  logic             high_le_low;

`ifdef SYNC_PERIOD_MEASURE_CDC_EN
  logic meta_q, sync2_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta_q  <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      meta_q  <= bus.i_sync;
      sync2_q <= meta_q;
    end
  end

  assign sync_in = sync2_q;
`else
  assign sync_in = bus.i_sync;
`endif

  assign rise        = s_sync_q & ~s_last_q;
  assign low_cnt     = cnt_q - hcnt_q;
  assign high_le_low = (hcnt_q <= low_cnt);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_WAIT;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      s_sync_q <= 1'b0;
      s_last_q <= 1'b0;
      v_q      <= 1'b0;
      lost_q   <= 1'b0;
      period_q <= '0;
      width_q  <= '0;
      pol_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      s_sync_q <= sync_in;
      s_last_q <= s_sync_q;
      v_q      <= v_d;
      lost_q   <= lost_d;
      period_q <= period_d;
      width_q  <= width_d;
      pol_q    <= pol_d;
    end
  end

  // hcnt only ever grows alongside cnt, so saturating cnt bounds both.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      S_WAIT: begin
        if (rise) begin
          cnt_d   = CNT_ONE;
          hcnt_d  = CNT_ONE;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (rise) begin
          cnt_d  = CNT_ONE;
          hcnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_WAIT;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          hcnt_d = hcnt_q + {{(NBITS-1){1'b0}}, s_sync_q};
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // A rise on the saturation cycle is a valid period, so it takes priority.
  always_comb begin
    v_d      = 1'b0;
    lost_d   = 1'b0;
    period_d = period_q;
    width_d  = width_q;
    pol_d    = pol_q;
    if (state_q == S_RUN) begin
      if (rise) begin
        v_d      = 1'b1;
        period_d = cnt_q;
        width_d  = high_le_low ? hcnt_q : low_cnt;
        pol_d    = high_le_low;
      end else if (cnt_q == CNT_MAX) begin
        v_d      = 1'b1;
        lost_d   = 1'b1;
        period_d = '0;
        width_d  = '0;
        pol_d    = 1'b0;
      end
    end
  end

  assign bus.o_v      = v_q;
  assign bus.o_lost   = lost_q;
  assign bus.o_period = period_q;
  assign bus.o_width  = width_q;
  assign bus.o_pol    = pol_q;

endmodule
